mmcm_lock_sequencer: RTL and testbench

//  Controls the MMCM reset. Holds the MMCM in reset, waits for LOCKED with a timeout
//  and retries a limited number of times. Requires lock to be stable before releasing
//  the downstream system reset (rstb), filters glitches on lock loss, and forces a relock.

---
 rtl/clk_mgmt_pkg.sv | 52 +++++
 rtl/sync_2ff.sv | 26 ++
 rtl/mmcm_lock_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_mmcm_lock_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mgmt_pkg.sv
// Shared clock-management definitions: MMCM lock sequencer state encoding,
// default timing constants used by clock_generation integration, and small
// elaboration-time helpers for sizing counters.
package clk_mgmt_pkg;

  // FSM state encoding (3 bits); codes 5-7 are illegal
  localparam int STATE_W = 3;
  localparam logic [2:0] ST_RST_ASSERT  = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] ST_STABLE_WAIT = 3'd2;
  localparam logic [2:0] ST_RUN         = 3'd3;
  localparam logic [2:0] ST_FAULT       = 3'd4;

  // Default timing for a 100 MHz board clock
  localparam int DEF_CLK_FREQUENCY       = 100_000_000;
  localparam int DEF_RST_HOLD_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 100_000;
  localparam int DEF_STABLE_CYCLES       = 1024;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_LOSS_FILTER_CYCLES  = 4;

  // Status counter widths
  localparam int RETRY_W  = 4;
  localparam int RELOCK_W = 16;

  // Largest of three cycle counts, used to size the shared phase timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Bits needed to hold the value max_count without wrapping
  function automatic int counter_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end else begin
      return $clog2(max_count + 1);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear on the synchronous reset so the output starts at 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture the asynchronous input and let the second stage resolve metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/mmcm_lock_sequencer.sv
// MMCM reset / lock sequencer. Holds the MMCM in reset, waits for LOCKED with
// a timeout and a bounded number of retries, demands a stable lock before
// releasing the downstream reset (rstb), filters short lock-loss glitches in
// RUN and forces a relock on a real loss. Runs on the free-running board clock.
module mmcm_lock_sequencer
  import clk_mgmt_pkg::*;
#(
  parameter int CLK_FREQUENCY       = DEF_CLK_FREQUENCY,
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int LOSS_FILTER_CYCLES  = DEF_LOSS_FILTER_CYCLES
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                mmcm_locked_in,
  input  logic                soft_reset_req,
  output logic                mmcm_rst_out,
  output logic                rstb,
  output logic                fault,
  output logic [STATE_W-1:0]  state_out,
  output logic [RETRY_W-1:0]  retry_count,
  output logic [RELOCK_W-1:0] relock_count
);

  // One timer serves RST_ASSERT, WAIT_LOCK and STABLE_WAIT, so it is sized
  // for the longest of the three phases and saturates there.
  localparam int TIMER_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int TIMER_W   = counter_width(TIMER_MAX);
  localparam int LOSS_W    = counter_width(LOSS_FILTER_CYCLES);

  // Phase ends on the edge that closes its last cycle, i.e. when the timer
  // (cycles already spent) equals the phase length minus one.
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMER_SAT    = TIMER_W'(TIMER_MAX);
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

  localparam logic [LOSS_W-1:0]   LOSS_ONE    = LOSS_W'(1);
  localparam logic [LOSS_W-1:0]   LOSS_SAT    = LOSS_W'(LOSS_FILTER_CYCLES);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER_CYCLES - 1);

  localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [RELOCK_W-1:0] RELOCK_SAT  = 16'hFFFF;

  // Reject parameter sets the counters cannot represent
  if (CLK_FREQUENCY < 1 || RST_HOLD_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
      STABLE_CYCLES < 1 || LOSS_FILTER_CYCLES < 1 ||
      MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_params
    $error("mmcm_lock_sequencer: parameter out of range");
  end

  // Registered state
  logic [STATE_W-1:0]  state_r;
  logic [TIMER_W-1:0]  timer_r;
  logic [LOSS_W-1:0]   loss_cnt_r;
  logic [RETRY_W-1:0]  retry_r;
  logic [RELOCK_W-1:0] relock_count_r;
  logic                mmcm_rst_r;
  logic                rstb_r;
  logic                fault_r;

  // Next-state values
  logic                lk_s;
  logic [STATE_W-1:0]  state_nxt_s;
  logic [TIMER_W-1:0]  timer_nxt_s;
  logic [LOSS_W-1:0]   loss_nxt_s;
  logic [RETRY_W-1:0]  retry_nxt_s;
  logic [RELOCK_W-1:0] relock_nxt_s;
  logic                restart_s;

  sync_2ff u_lock_sync (
    .clk (clk_in),
    .rst (rst),
    .d   (mmcm_locked_in),
    .q   (lk_s)
  );

  // FSM transitions; soft reset overrides everything, timeout/loss beat lock events
  always_comb begin
    state_nxt_s  = state_r;
    retry_nxt_s  = retry_r;
    relock_nxt_s = relock_count_r;
    if (soft_reset_req) begin
      state_nxt_s = ST_RST_ASSERT;
      retry_nxt_s = 4'd0;
    end else begin
      case (state_r)
        ST_RST_ASSERT: begin
          if (timer_r == HOLD_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else begin
            state_nxt_s = ST_RST_ASSERT;
          end
        end
        ST_WAIT_LOCK: begin
          if (timer_r == TIMEOUT_LAST) begin
            if (retry_r < RETRY_LIMIT) begin
              retry_nxt_s = retry_r + 4'd1;
              state_nxt_s = ST_RST_ASSERT;
            end else begin
              state_nxt_s = ST_FAULT;
            end
          end else if (lk_s) begin
            state_nxt_s = ST_STABLE_WAIT;
          end else begin
            state_nxt_s = ST_WAIT_LOCK;
          end
        end
        ST_STABLE_WAIT: begin
          if (!lk_s) begin
            state_nxt_s = ST_WAIT_LOCK;
          end else if (timer_r == STABLE_LAST) begin
            state_nxt_s = ST_RUN;
            retry_nxt_s = 4'd0;
          end else begin
            state_nxt_s = ST_STABLE_WAIT;
          end
        end
        ST_RUN: begin
          if (!lk_s && (loss_cnt_r == LOSS_LAST)) begin
            state_nxt_s = ST_RST_ASSERT;
            if (relock_count_r != RELOCK_SAT) begin
              relock_nxt_s = relock_count_r + 16'd1;
            end else begin
              relock_nxt_s = relock_count_r;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FAULT: begin
          state_nxt_s = ST_FAULT;
        end
        default: begin
          state_nxt_s = ST_RST_ASSERT;
        end
      endcase
    end
  end

  // Phase timer and loss filter: clear on any state change or restart, else saturate
  always_comb begin
    restart_s   = soft_reset_req || (state_nxt_s != state_r);
    timer_nxt_s = timer_r;
    loss_nxt_s  = loss_cnt_r;
    if (restart_s) begin
      timer_nxt_s = '0;
      loss_nxt_s  = '0;
    end else begin
      if (timer_r == TIMER_SAT) begin
        timer_nxt_s = timer_r;
      end else begin
        timer_nxt_s = timer_r + TIMER_ONE;
      end
      if ((state_r == ST_RUN) && !lk_s) begin
        if (loss_cnt_r == LOSS_SAT) begin
          loss_nxt_s = loss_cnt_r;
        end else begin
          loss_nxt_s = loss_cnt_r + LOSS_ONE;
        end
      end else begin
        loss_nxt_s = '0;
      end
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so they
  // change on the same edge as the state they describe
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r        <= ST_RST_ASSERT;
      timer_r        <= '0;
      loss_cnt_r     <= '0;
      retry_r        <= 4'd0;
      relock_count_r <= 16'd0;
      mmcm_rst_r     <= 1'b1;
      rstb_r         <= 1'b0;
      fault_r        <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      timer_r        <= timer_nxt_s;
      loss_cnt_r     <= loss_nxt_s;
      retry_r        <= retry_nxt_s;
      relock_count_r <= relock_nxt_s;
      mmcm_rst_r     <= (state_nxt_s == ST_RST_ASSERT) || (state_nxt_s == ST_FAULT);
      rstb_r         <= (state_nxt_s == ST_RUN);
      fault_r        <= (state_nxt_s == ST_FAULT);
    end
  end

  assign mmcm_rst_out = mmcm_rst_r;
  assign rstb         = rstb_r;
  assign fault        = fault_r;
  assign state_out    = state_r;
  assign retry_count  = retry_r;
  assign relock_count = relock_count_r;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Directed bench for mmcm_lock_sequencer with short timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmcm_lock_sequencer;

  logic        clk;
  logic        rst;
  logic        mmcm_locked_in;
  logic        soft_reset_req;
  logic        mmcm_rst_out;
  logic        rstb;
  logic        fault;
  logic [2:0]  state_out;
  logic [3:0]  retry_count;
  logic [15:0] relock_count;

  int checks = 0;
  int errors = 0;

  mmcm_lock_sequencer #(
    .CLK_FREQUENCY       (100_000_000),
    .RST_HOLD_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .STABLE_CYCLES       (8),
    .MAX_RETRIES         (2),
    .LOSS_FILTER_CYCLES  (3)
  ) dut (
    .clk_in         (clk),
    .rst            (rst),
    .mmcm_locked_in (mmcm_locked_in),
    .soft_reset_req (soft_reset_req),
    .mmcm_rst_out   (mmcm_rst_out),
    .rstb           (rstb),
    .fault          (fault),
    .state_out      (state_out),
    .retry_count    (retry_count),
    .relock_count   (relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count consecutive samples (including the current one) with state_out == st
  task automatic count_state(input logic [2:0] st, input int limit, output int n);
    n = 0;
    while (state_out === st && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Count consecutive samples (including the current one) with mmcm_rst_out high
  task automatic count_pulse(input int limit, output int n);
    n = 0;
    while (mmcm_rst_out === 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Bounded wait for a state; an expired bound is a failed comparison
  task automatic wait_state(input logic [2:0] st, input int limit, input string name);
    int k;
    k = 0;
    while (state_out !== st && k < limit) begin
      k++;
      @(negedge clk);
    end
    checks++;
    if (state_out !== st) begin
      errors++;
      $display("FAIL %s: state_out=%0d, expected %0d within %0d cycles", name, state_out, st, limit);
    end
  endtask

  // Bounded wait for rstb to reach a level
  task automatic wait_rstb(input logic val, input int limit, input string name);
    int k;
    k = 0;
    while (rstb !== val && k < limit) begin
      k++;
      @(negedge clk);
    end
    checks++;
    if (rstb !== val) begin
      errors++;
      $display("FAIL %s: rstb=%b, expected %b within %0d cycles", name, rstb, val, limit);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mmcm_locked_in = 1'b0;
    soft_reset_req = 1'b0;
    @(negedge clk);
    checks += 6;
    if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, expected 0", state_out); end
    if (mmcm_rst_out !== 1'b1) begin errors++; $display("FAIL reset_mmcm_rst: got %b, expected 1", mmcm_rst_out); end
    if (rstb !== 1'b0) begin errors++; $display("FAIL reset_rstb: got %b, expected 0", rstb); end
    if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b, expected 0", fault); end
    if (retry_count !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d, expected 0", retry_count); end
    if (relock_count !== 16'd0) begin errors++; $display("FAIL reset_relock: got %0d, expected 0", relock_count); end
    rst = 1'b0;
  endtask

  task automatic test_lock_sequence;
    int n;
    count_pulse(20, n);
    checks += 2;
    if (n !== 4) begin errors++; $display("FAIL t1_rst_pulse: got %0d cycles, expected 4", n); end
    if (state_out !== 3'd1) begin errors++; $display("FAIL t1_wait_lock: got %0d, expected 1", state_out); end
    repeat (3) @(negedge clk);
    mmcm_locked_in = 1'b1;
    wait_state(3'd2, 10, "t1_enter_stable");
    count_state(3'd2, 20, n);
    checks += 5;
    if (n !== 8) begin errors++; $display("FAIL t1_stable_len: got %0d cycles, expected 8", n); end
    if (state_out !== 3'd3) begin errors++; $display("FAIL t1_run: got %0d, expected 3", state_out); end
    if (rstb !== 1'b1) begin errors++; $display("FAIL t1_rstb: got %b, expected 1", rstb); end
    if (retry_count !== 4'd0) begin errors++; $display("FAIL t1_retry: got %0d, expected 0", retry_count); end
    if (mmcm_rst_out !== 1'b0) begin errors++; $display("FAIL t1_mmcm_rst: got %b, expected 0", mmcm_rst_out); end
  endtask

  task automatic test_timeout_fault;
    int n;
    rst = 1'b1;
    mmcm_locked_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_pulse(20, n);
    for (int r = 1; r <= 2; r++) begin
      count_state(3'd1, 40, n);
      checks += 4;
      if (n !== 20) begin errors++; $display("FAIL t2_wait_len%0d: got %0d cycles, expected 20", r, n); end
      if (state_out !== 3'd0) begin errors++; $display("FAIL t2_retry_state%0d: got %0d, expected 0", r, state_out); end
      if (retry_count !== 4'(r)) begin errors++; $display("FAIL t2_retry_count%0d: got %0d, expected %0d", r, retry_count, r); end
      count_pulse(20, n);
      if (n !== 4) begin errors++; $display("FAIL t2_retry_pulse%0d: got %0d cycles, expected 4", r, n); end
    end
    count_state(3'd1, 40, n);
    checks += 5;
    if (n !== 20) begin errors++; $display("FAIL t2_wait_len3: got %0d cycles, expected 20", n); end
    if (state_out !== 3'd4) begin errors++; $display("FAIL t2_fault_state: got %0d, expected 4", state_out); end
    if (fault !== 1'b1) begin errors++; $display("FAIL t2_fault: got %b, expected 1", fault); end
    if (mmcm_rst_out !== 1'b1) begin errors++; $display("FAIL t2_fault_mmcm_rst: got %b, expected 1", mmcm_rst_out); end
    if (rstb !== 1'b0) begin errors++; $display("FAIL t2_fault_rstb: got %b, expected 0", rstb); end
    repeat (5) @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin errors++; $display("FAIL t2_fault_sticky: got %b, expected 1", fault); end
    soft_reset_req = 1'b1;
    @(negedge clk);
    soft_reset_req = 1'b0;
    checks += 4;
    if (fault !== 1'b0) begin errors++; $display("FAIL t2_soft_fault: got %b, expected 0", fault); end
    if (state_out !== 3'd0) begin errors++; $display("FAIL t2_soft_state: got %0d, expected 0", state_out); end
    if (retry_count !== 4'd0) begin errors++; $display("FAIL t2_soft_retry: got %0d, expected 0", retry_count); end
    if (mmcm_rst_out !== 1'b1) begin errors++; $display("FAIL t2_soft_mmcm_rst: got %b, expected 1", mmcm_rst_out); end
  endtask

  task automatic test_loss_filter;
    int drops;
    int n;
    mmcm_locked_in = 1'b1;
    wait_state(3'd3, 40, "t3_reach_run");
    mmcm_locked_in = 1'b0;
    repeat (2) @(negedge clk);
    mmcm_locked_in = 1'b1;
    drops = 0;
    repeat (8) begin
      @(negedge clk);
      if (rstb !== 1'b1) drops++;
    end
    checks += 3;
    if (drops !== 0) begin errors++; $display("FAIL t3_glitch_rstb: rstb low for %0d cycles, expected 0", drops); end
    if (relock_count !== 16'd0) begin errors++; $display("FAIL t3_glitch_relock: got %0d, expected 0", relock_count); end
    if (state_out !== 3'd3) begin errors++; $display("FAIL t3_glitch_state: got %0d, expected 3", state_out); end
    mmcm_locked_in = 1'b0;
    repeat (3) @(negedge clk);
    mmcm_locked_in = 1'b1;
    wait_rstb(1'b0, 6, "t3_loss_rstb");
    checks += 4;
    if (relock_count !== 16'd1) begin errors++; $display("FAIL t3_loss_relock: got %0d, expected 1", relock_count); end
    if (state_out !== 3'd0) begin errors++; $display("FAIL t3_loss_state: got %0d, expected 0", state_out); end
    if (mmcm_rst_out !== 1'b1) begin errors++; $display("FAIL t3_loss_mmcm_rst: got %b, expected 1", mmcm_rst_out); end
    count_pulse(20, n);
    if (n !== 4) begin errors++; $display("FAIL t3_loss_pulse: got %0d cycles, expected 4", n); end
  endtask

  task automatic test_stable_drop;
    int n;
    wait_state(3'd2, 5, "t4_enter_stable");
    repeat (3) @(negedge clk);
    mmcm_locked_in = 1'b0;
    count_state(3'd2, 20, n);
    checks += 4;
    if (n !== 3) begin errors++; $display("FAIL t4_drop_latency: got %0d cycles, expected 3", n); end
    if (state_out !== 3'd1) begin errors++; $display("FAIL t4_back_wait: got %0d, expected 1", state_out); end
    if (rstb !== 1'b0) begin errors++; $display("FAIL t4_rstb: got %b, expected 0", rstb); end
    if (retry_count !== 4'd0) begin errors++; $display("FAIL t4_retry: got %0d, expected 0", retry_count); end
    mmcm_locked_in = 1'b1;
    wait_state(3'd2, 6, "t4_reenter_stable");
    count_state(3'd2, 20, n);
    checks += 2;
    if (n !== 8) begin errors++; $display("FAIL t4_full_stable: got %0d cycles, expected 8", n); end
    if (rstb !== 1'b1) begin errors++; $display("FAIL t4_run_rstb: got %b, expected 1", rstb); end
  endtask

  task automatic test_reset_midway;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (state_out !== 3'd0) begin errors++; $display("FAIL t5_run_state: got %0d, expected 0", state_out); end
    if (mmcm_rst_out !== 1'b1) begin errors++; $display("FAIL t5_run_mmcm_rst: got %b, expected 1", mmcm_rst_out); end
    if (rstb !== 1'b0) begin errors++; $display("FAIL t5_run_rstb: got %b, expected 0", rstb); end
    if (relock_count !== 16'd0) begin errors++; $display("FAIL t5_run_relock: got %0d, expected 0", relock_count); end
    if (fault !== 1'b0) begin errors++; $display("FAIL t5_run_fault: got %b, expected 0", fault); end
    wait_state(3'd2, 20, "t5_reach_stable");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (state_out !== 3'd0) begin errors++; $display("FAIL t5_stable_state: got %0d, expected 0", state_out); end
    if (mmcm_rst_out !== 1'b1) begin errors++; $display("FAIL t5_stable_mmcm_rst: got %b, expected 1", mmcm_rst_out); end
    if (rstb !== 1'b0) begin errors++; $display("FAIL t5_stable_rstb: got %b, expected 0", rstb); end
    if (retry_count !== 4'd0) begin errors++; $display("FAIL t5_stable_retry: got %0d, expected 0", retry_count); end
  endtask

  task automatic test_relock_saturation;
    wait_state(3'd3, 40, "t6_reach_run");
    force dut.relock_count_r = 16'hFFFE;
    @(negedge clk);
    release dut.relock_count_r;
    @(negedge clk);
    checks++;
    if (relock_count !== 16'hFFFE) begin errors++; $display("FAIL t6_preload: got %h, expected fffe", relock_count); end
    for (int i = 0; i < 3; i++) begin
      mmcm_locked_in = 1'b0;
      wait_rstb(1'b0, 8, "t6_loss_rstb");
      checks++;
      if (relock_count !== 16'hFFFF) begin errors++; $display("FAIL t6_sat%0d: got %h, expected ffff", i, relock_count); end
      mmcm_locked_in = 1'b1;
      wait_state(3'd3, 40, "t6_relock_run");
    end
  endtask

  // Hard stop in case a wait somewhere is unbounded
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock_sequence();
    test_timeout_fault();
    test_loss_filter();
    test_stable_drop();
    test_reset_midway();
    test_relock_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
